// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR2 write-data path.
package ddr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PRE,
    DATA,
    POST
  } ddr_wstate_t;

  localparam int BEATS_BL4 = 2;
  localparam int BEATS_BL8 = 4;

  // DQS levels: preamble/postamble hold DQS low, data cycles toggle high-then-low
  localparam logic DQS_PRE_D0  = 1'b0;
  localparam logic DQS_PRE_D1  = 1'b0;
  localparam logic DQS_DATA_D0 = 1'b1;
  localparam logic DQS_DATA_D1 = 1'b0;

endpackage

// File: rtl/ddr_wdata_serializer.sv
// DDR2 write-data front end: latency wait, DQS pre/postamble framing and
// per-beat d0/d1 split with masked filler on underrun. All outputs registered.
module ddr_wdata_serializer
  import ddr_pkg::*;
#(
  parameter int DQ_WIDTH      = 16,
  parameter int WRITE_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic                    cmd_bl8,
  output logic                    cmd_ready,
  input  logic                    wr_valid,
  input  logic [2*DQ_WIDTH-1:0]   wr_data,
  input  logic [2*DQ_WIDTH/8-1:0] wr_dm,
  output logic                    wr_ready,
  output logic [DQ_WIDTH-1:0]     d0,
  output logic [DQ_WIDTH-1:0]     d1,
  output logic [DQ_WIDTH/8-1:0]   dm0,
  output logic [DQ_WIDTH/8-1:0]   dm1,
  output logic                    dq_t,
  output logic                    dqs0,
  output logic                    dqs1,
  output logic                    dqs_t,
  output logic                    underrun
);

  localparam int         DMW       = DQ_WIDTH / 8;
  localparam logic [3:0] WAIT_LOAD = 4'(WRITE_LATENCY - 2);

  ddr_wstate_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  last_beat;
  logic        bl8_q, bl8_d;
  logic        go_q, go_d;
  logic        accept;

  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic [DQ_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [DMW-1:0]      dm0_q, dm0_d, dm1_q, dm1_d;
  logic                dq_t_q, dq_t_d, dqs_t_q, dqs_t_d;
  logic                dqs0_q, dqs0_d, dqs1_q, dqs1_d;
  logic                underrun_q, underrun_d;

  assign accept    = cmd_valid && cmd_ready_q;
  assign last_beat = bl8_q ? 2'(BEATS_BL8 - 1) : 2'(BEATS_BL4 - 1);

  // go_q marks the cycle right after acceptance, so PRE lands on cycle
  // WRITE_LATENCY-1 even when WAIT is skipped entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    bl8_d   = bl8_q;
    go_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_q) begin
          if (WAIT_LOAD == 4'd0) begin
            state_d = PRE;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else if (accept) begin
          go_d  = 1'b1;
          bl8_d = cmd_bl8;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = PRE;
      end
      PRE: begin
        state_d = DATA;
        beat_d  = 2'd0;
      end
      DATA: begin
        if (beat_q == last_beat) state_d = POST;
        else                     beat_d  = beat_q + 2'd1;
      end
      POST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the state being entered. wr_ready leads DATA by one cycle
  // so each handshake edge is also the edge that loads that beat into d0/d1.
  always_comb begin
    cmd_ready_d = (state_d == IDLE) && !go_d;
    wr_ready_d  = (state_d == PRE) || ((state_d == DATA) && (beat_d != last_beat));
    dq_t_d      = (state_d != DATA);
    dqs_t_d     = !(state_d inside {PRE, DATA, POST});
    dqs0_d      = 1'b0;
    dqs1_d      = 1'b0;
    d0_d        = '0;
    d1_d        = '0;
    dm0_d       = '0;
    dm1_d       = '0;
    underrun_d  = 1'b0;
    if (state_d == PRE || state_d == POST) begin
      dqs0_d = DQS_PRE_D0;
      dqs1_d = DQS_PRE_D1;
    end
    if (state_d == DATA) begin
      dqs0_d = DQS_DATA_D0;
      dqs1_d = DQS_DATA_D1;
      if (wr_valid && wr_ready_q) begin
        d0_d  = wr_data[DQ_WIDTH-1:0];
        d1_d  = wr_data[2*DQ_WIDTH-1:DQ_WIDTH];
        dm0_d = wr_dm[DMW-1:0];
        dm1_d = wr_dm[2*DMW-1:DMW];
      end else begin
        dm0_d      = '1;
        dm1_d      = '1;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      bl8_q       <= 1'b0;
      go_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      dm0_q       <= '0;
      dm1_q       <= '0;
      dq_t_q      <= 1'b1;
      dqs_t_q     <= 1'b1;
      dqs0_q      <= 1'b0;
      dqs1_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      bl8_q       <= bl8_d;
      go_q        <= go_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      dm0_q       <= dm0_d;
      dm1_q       <= dm1_d;
      dq_t_q      <= dq_t_d;
      dqs_t_q     <= dqs_t_d;
      dqs0_q      <= dqs0_d;
      dqs1_q      <= dqs1_d;
      underrun_q  <= underrun_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign d0        = d0_q;
  assign d1        = d1_q;
  assign dm0       = dm0_q;
  assign dm1       = dm1_q;
  assign dq_t      = dq_t_q;
  assign dqs0      = dqs0_q;
  assign dqs1      = dqs1_q;
  assign dqs_t     = dqs_t_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_ddr_wdata_serializer.sv
// Scoreboard bench: bursts push expected beats, a negedge monitor pops and
// compares every driven beat; framing timing is checked inline.
module tb_ddr_wdata_serializer;

  localparam int WL  = 3;
  localparam int WL2 = 2;

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  dm0;
    logic [1:0]  dm1;
    logic        ur;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        cmd_valid = 0, cmd_bl8 = 0, cmd_ready;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_dm = '0;
  logic [15:0] d0, d1;
  logic [1:0]  dm0, dm1;
  logic        dq_t, dqs0, dqs1, dqs_t, underrun;

  logic        c2_valid = 0, c2_ready;
  logic        w2_valid = 0, w2_ready;
  logic [31:0] w2_data = '0;
  logic [15:0] e0, e1;
  logic [1:0]  em0, em1;
  logic        e_dq_t, e_dqs0, e_dqs1, e_dqs_t, e_underrun;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b1;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  ddr_wdata_serializer #(.DQ_WIDTH(16), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_bl8(cmd_bl8), .cmd_ready(cmd_ready),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_dm(wr_dm), .wr_ready(wr_ready),
    .d0(d0), .d1(d1), .dm0(dm0), .dm1(dm1), .dq_t(dq_t), .dqs0(dqs0), .dqs1(dqs1),
    .dqs_t(dqs_t), .underrun(underrun)
  );

  ddr_wdata_serializer #(.DQ_WIDTH(16), .WRITE_LATENCY(WL2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_bl8(1'b0), .cmd_ready(c2_ready),
    .wr_valid(w2_valid), .wr_data(w2_data), .wr_dm(4'b0000), .wr_ready(w2_ready),
    .d0(e0), .d1(e1), .dm0(em0), .dm1(em1), .dq_t(e_dq_t), .dqs0(e_dqs0), .dqs1(e_dqs1),
    .dqs_t(e_dqs_t), .underrun(e_underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every cycle the DUT drives DQ is one beat.
  always @(negedge clk) begin
    if (mon_en && !rst && dq_t === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got d0=%0h d1=%0h expected no beat", d0, d1);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_d0", 32'(d0), 32'(e.d0));
        chk("beat_d1", 32'(d1), 32'(e.d1));
        chk("beat_dm", {28'd0, dm1, dm0}, {28'd0, e.dm1, e.dm0});
        chk("beat_underrun", 32'(underrun), 32'(e.ur));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) return;
      tick();
    end
    chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // One burst; ub = index of the beat presented without wr_valid (-1: none).
  task automatic burst(input bit bl8, input logic [31:0] w0, w1, w2, w3,
                       input logic [3:0] m0, m1, m2, m3, input int ub);
    logic [31:0] w[4];
    logic [3:0]  m[4];
    int beats, j, hs;
    beat_t e;
    w = '{w0, w1, w2, w3};
    m = '{m0, m1, m2, m3};
    beats = bl8 ? 4 : 2;
    for (int k = 0; k < beats; k++) begin
      if (k == ub) e = '{16'h0, 16'h0, 2'b11, 2'b11, 1'b1};
      else         e = '{w[k][15:0], w[k][31:16], m[k][1:0], m[k][3:2], 1'b0};
      exp_q.push_back(e);
    end
    wait_ready();
    cmd_valid = 1'b1;
    cmd_bl8   = bl8;
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
    j  = 0;
    hs = 0;
    for (int c = 0; c <= WL + beats + 1; c++) begin
      if (c < WL - 1) chk("wr_ready_early", 32'(wr_ready), 32'd0);
      if (c == WL - 1) begin
        chk("pre_dqs_t", 32'(dqs_t), 32'd0);
        chk("pre_dqs", {30'd0, dqs1, dqs0}, 32'd0);
        chk("pre_dq_t", 32'(dq_t), 32'd1);
        chk("pre_wr_ready", 32'(wr_ready), 32'd1);
      end
      if (c >= WL && c < WL + beats) begin
        chk("data_dq_t", 32'(dq_t), 32'd0);
        chk("data_dqs", {30'd0, dqs1, dqs0}, 32'd1);
      end
      if (c == WL + beats) begin
        chk("post_dq_t", 32'(dq_t), 32'd1);
        chk("post_dqs_t", 32'(dqs_t), 32'd0);
        chk("post_dqs", {30'd0, dqs1, dqs0}, 32'd0);
        chk("post_wr_ready", 32'(wr_ready), 32'd0);
        chk("post_underrun", 32'(underrun), 32'd0);
      end
      if (c == WL + beats + 1) begin
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_dqs_t", 32'(dqs_t), 32'd1);
      end
      if (j < beats) begin
        wr_valid = (j != ub);
        wr_data  = w[j];
        wr_dm    = m[j];
      end else begin
        wr_valid = 1'b0;
      end
      if (wr_valid && wr_ready) hs++;
      if (wr_ready && j < beats) j++;
      tick();
    end
    wr_valid = 1'b0;
    chk("words_consumed", 32'(hs), 32'(beats - (ub >= 0 ? 1 : 0)));
  endtask

  initial begin
    int last_acc, n_acc;
    beat_t e;

    // reset values
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_dq_t", 32'(dq_t), 32'd1);
    chk("rst_dqs_t", 32'(dqs_t), 32'd1);
    chk("rst_data", {d1, d0}, 32'd0);
    chk("rst_misc", {26'd0, dm1, dm0, dqs1, dqs0, underrun}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);

    // BL4 directed, with explicit cycle-3/4 data
    exp_q.push_back('{16'hAAAA, 16'hBBBB, 2'b00, 2'b00, 1'b0});
    exp_q.push_back('{16'hCCCC, 16'hDDDD, 2'b00, 2'b00, 1'b0});
    cmd_valid = 1'b1; cmd_bl8 = 1'b0;
    tick();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hBBBB_AAAA; wr_dm = 4'b0000;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) chk("bl4_pre", {29'd0, dqs_t, dqs1, dqs0}, 32'd0);
      if (c == 3) chk("bl4_c3", {15'd0, dq_t, d0}, 32'h0000_AAAA);
      if (c == 4) chk("bl4_c4", {d1, d0}, 32'hDDDD_CCCC);
      if (c == 5) chk("bl4_post", {30'd0, dq_t, dqs_t}, 32'd2);
      if (c == 6) chk("bl4_cmd_ready", 32'(cmd_ready), 32'd1);
      if (c == 3) wr_data = 32'hDDDD_CCCC;
      if (c == 4) wr_valid = 1'b0;
      tick();
    end

    // BL8 with mask on beat 2, then BL8 underrun on beat 3, then BL4 with mask
    burst(1'b1, 32'h1111_0000, 32'h3333_2222, 32'h5555_4444, 32'h7777_6666,
          4'b0000, 4'b0101, 4'b0000, 4'b0000, -1);
    burst(1'b1, 32'hA0A0_0A0A, 32'hB1B1_1B1B, 32'hC2C2_2C2C, 32'hD3D3_3D3D,
          4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
    burst(1'b0, 32'hFEDC_BA98, 32'h7654_3210, 32'h0, 32'h0,
          4'b1000, 4'b0011, 4'b0000, 4'b0000, -1);

    // reset in the middle of DATA
    mon_en = 1'b0;
    wait_ready();
    cmd_valid = 1'b1; cmd_bl8 = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h5A5A_A5A5;
    for (int i = 0; i < 10 && dq_t; i++) tick();
    chk("mid_rst_in_data", 32'(dq_t), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_tristate", {30'd0, dq_t, dqs_t}, 32'd3);
    chk("mid_rst_d0", 32'(d0), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); tick();
    rst = 1'b0;
    wr_valid = 1'b0;
    tick();
    chk("mid_rst_release", 32'(cmd_ready), 32'd1);
    chk("mid_rst_no_post", 32'(dqs_t), 32'd1);
    mon_en = 1'b1;

    // cmd_valid held high, BL4 back-to-back
    cmd_bl8 = 1'b0; cmd_valid = 1'b1;
    wr_valid = 1'b1; wr_data = 32'h1234_5678; wr_dm = 4'b0000;
    last_acc = -1; n_acc = 0;
    for (int c = 0; c < 22; c++) begin
      if (cmd_ready && (!dq_t || !dqs_t)) chk("b2b_ready_busy", 32'(cmd_ready), 32'd0);
      if (cmd_ready) begin
        if (last_acc >= 0) chk("b2b_spacing", 32'(c - last_acc), 32'(WL + 4));
        last_acc = c;
        n_acc++;
        e = '{16'h5678, 16'h1234, 2'b00, 2'b00, 1'b0};
        exp_q.push_back(e);
        exp_q.push_back(e);
      end
      tick();
      if (last_acc == c - 1) chk("b2b_ready_drop", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(n_acc >= 3), 32'd1);
    for (int c = 0; c < 12; c++) tick();
    wr_valid = 1'b0;

    // WRITE_LATENCY=2 instance
    for (int i = 0; i < 20 && !c2_ready; i++) tick();
    c2_valid = 1'b1;
    tick();
    c2_valid = 1'b0;
    w2_valid = 1'b1; w2_data = 32'h2222_1111;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) chk("wl2_c0_idle", {30'd0, e_dq_t, e_dqs_t}, 32'd3);
      if (c == 1) begin
        chk("wl2_pre", {29'd0, e_dq_t, e_dqs_t, e_dqs0}, 32'd4);
        chk("wl2_pre_ready", 32'(w2_ready), 32'd1);
      end
      if (c == 2) chk("wl2_data", {15'd0, e_dq_t, e0}, 32'h0000_1111);
      if (c == 3) chk("wl2_data2", {e1, e0}, 32'h4444_3333);
      if (c == 4) chk("wl2_post", {30'd0, e_dq_t, e_dqs_t}, 32'd2);
      if (c == 5) chk("wl2_cmd_ready", 32'(c2_ready), 32'd1);
      if (c == 2) w2_data = 32'h4444_3333;
      if (c == 3) w2_valid = 1'b0;
      tick();
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
